fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Parametrised multiplexed 7-segment (FND) scanner for the BubbleDrive8 front panel. It drives DIGITS common-anode digits from a hex value bus, with frame-coherent value snapshots, per-digit decimal points, optional leading-zero blanking, 8-level PWM brightness and a ring-chase "waiting" animation. It sits between the emulator status signals and the panel pins, and replaces the fixed 3-digit driver.

## Interface
- DIGITS, 3, number of digits (1..8); position p = DIGITS-1 is the leftmost digit.
- SCAN_DIV, 1024, MCLK cycles per digit slot; must be a power of two and ≥ 8.
- ANIM_DIV, 16777216, MCLK cycles per animation step; must be ≥ 2.
- MCLK  in  1  48 MHz clock; the block's only clock.
- nRESET  in  1  asynchronous, active-low reset.
- nWAIT  in  1  0 = waiting animation mode, 1 = value mode; synchronous to MCLK.
- VALUE  in  4*DIGITS  hex nibbles; nibble p is VALUE[4p+3:4p].
- DP_MASK  in  DIGITS  bit p = 1 lights the decimal point of digit p.
- LZ_BLANK  in  1  1 = blank leading zero digits.
- BRIGHT  in  3  brightness level 0..7.
- nFND  out  8  segments {a,b,c,d,e,f,g,dp}; active-low.
- nANODE  out  DIGITS  bit p = 0 enables digit p.

## Operation
- Counters:
  - scnt runs 0..SCAN_DIV-1.
  - dig steps DIGITS-1 down to 0 when scnt wraps, then returns to DIGITS-1.
  - One frame is DIGITS*SCAN_DIV cycles.
- Snapshot:
  - VALUE, DP_MASK, LZ_BLANK and BRIGHT are latched on the edge where scnt==0 and dig==DIGITS-1.
  - Inputs are ignored for the rest of the frame.
- Value mode glyphs, nFND[7:1] for 0..F (hex pairs include the dp bit as 1):
  - 0–7: 03,9F,25,0D,99,49,41,1B
  - 8–F: 01,09,11,C1,E5,85,61,71
- Decimal point: nFND[0] = ~DP_MASK_snap[dig].
- Leading-zero blanking: when LZ_BLANK_snap=1, digit p > 0 shows no segments (a–g high) if its nibble and every higher nibble are zero. Digit 0 is never blanked. The DP still follows DP_MASK.
- Animation mode (nWAIT==0, sampled each cycle, not snapshotted):
  - The ring has L = 2*DIGITS+4 positions; position counter pos runs 0..L-1.
  - i = DIGITS-1-p is the index from the left.
  - pos 0..DIGITS-1: segment a of digit i=pos.
  - pos DIGITS: segment b of the rightmost digit; pos DIGITS+1: segment c of the rightmost digit.
  - pos DIGITS+2..2*DIGITS+1: segment d of digit i = 2*DIGITS+1-pos.
  - pos L-2: segment e of the leftmost digit; pos L-1: segment f of the leftmost digit.
  - All other segments and the DP are off. DP_MASK and LZ_BLANK are ignored.
- Animation counters:
  - acnt counts MCLK cycles while nWAIT==0; pos increments when acnt reaches ANIM_DIV-1, and pos wraps L-1 → 0.
  - While nWAIT==1, acnt and pos are held at 0, so every wait episode starts at pos 0.
- Brightness (both modes):
  - ON = (BRIGHT_snap+1)*SCAN_DIV/8.
  - nANODE[dig] = 0 only for 1 ≤ scnt < ON; all other anodes are 1.
  - scnt==0 is always dark (ghost-blanking guard).
  - BRIGHT=7 gives SCAN_DIV-1 lit cycles per slot.

## Timing
- Reset: nFND=8'hFF, nANODE=all 1, scnt=0, dig=DIGITS-1, acnt=0, pos=0, snapshot registers=0.
- nFND and nANODE are registered. The values presented after edge t are computed from the scnt, dig, pos and nWAIT values present before edge t, combined with the snapshot.
- The snapshot edge itself produces dark output, so new snapshot data is first visible at scnt=1 of the first slot. Latency from a VALUE change is at most one frame plus 2 cycles.
- A change in nWAIT takes effect on the output 1 cycle later, mid-frame, with no glitch on the anode timing.
- If nRESET is asserted mid-frame, all outputs go dark immediately (asynchronously). Scanning restarts at dig=DIGITS-1 on the first edge after release, and that edge loads a new snapshot.

## Test plan
All scenarios use DIGITS=3, SCAN_DIV=16, ANIM_DIV=8.
1. Reset, then VALUE=12'h3A0, BRIGHT=7, nWAIT=1 → nANODE cycles 011, 101, 110. Each slot shows 15 lit cycles plus 1 dark cycle. nFND = 0x0D, 0x11, 0x03 for the three digits.
2. VALUE=12'h005, LZ_BLANK=1, DP_MASK=3'b010 → digit 2 shows 0xFF; digit 1 shows 0xFE (DP only); digit 0 shows 0x49.
3. Change VALUE mid-frame → no change until the next frame start; the new glyph appears at scnt=1 of digit 2.
4. BRIGHT=0 → each anode is low for exactly cycle 1 of its slot (ON=2); BRIGHT=3 → low for cycles 1..7.
5. nWAIT=0 for 90 cycles → pos advances every 8 cycles through 0..9 and wraps to 0. At pos 4, digit 0 shows 0xDF (segment c). nWAIT=1 then 0 again → pos restarts at 0.
6. Assert nRESET at scnt=9 of digit 1 → outputs become FF/111 with no clock edge. After release, scanning resumes at digit 2 and the snapshot reloads.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
//
// Multiplexed common-anode 7-segment scanner for the BubbleDrive8 front panel.
// Each digit owns a SCAN_DIV-cycle slot. Digits are scanned from the leftmost
// (p = DIGITS-1) down to the rightmost (p = 0). The display inputs are captured
// once per frame, so every digit of a frame comes from the same value. In
// value mode each digit shows a hex glyph with an optional decimal point, and
// leading zeros can be blanked. In waiting mode (nWAIT = 0) a single lit
// segment chases around the outer ring of the display. Brightness is a
// per-slot on-time from 1/8 to 8/8 of the slot. The first cycle of every slot
// is always dark, which hides ghosting while the anodes switch.
//
// Parameters
//   DIGITS    number of digits (1..8)
//   SCAN_DIV  MCLK cycles per digit slot (power of two, >= 8)
//   ANIM_DIV  MCLK cycles per animation step (>= 2)
//
// Ports
//   MCLK      in   clock
//   nRESET    in   asynchronous active-low reset
//   nWAIT     in   0 = waiting animation, 1 = value display
//   VALUE     in   4*DIGITS hex nibbles, nibble p drives digit p
//   DP_MASK   in   per-digit decimal point enable
//   LZ_BLANK  in   blank leading zero digits
//   BRIGHT    in   brightness 0..7
//   nFND      out  segments {a,b,c,d,e,f,g,dp}, active-low, registered
//   nANODE    out  digit enables, active-low, registered
// -----------------------------------------------------------------------------
module fnd_scan_driver #(
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1024,
   parameter int ANIM_DIV = 16777216
) (
   input  logic                  MCLK,
   input  logic                  nRESET,
   input  logic                  nWAIT,
   input  logic [4*DIGITS-1:0]   VALUE,
   input  logic [DIGITS-1:0]     DP_MASK,
   input  logic                  LZ_BLANK,
   input  logic [2:0]            BRIGHT,
   output logic [7:0]            nFND,
   output logic [DIGITS-1:0]     nANODE
);

   localparam int SW       = $clog2(SCAN_DIV);
   localparam int DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int RING_LEN = 2 * DIGITS + 4;
   localparam int PW       = $clog2(RING_LEN);
   localparam int AW       = $clog2(ANIM_DIV);

   localparam logic [SW-1:0] SCNT_MAX = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_MAX  = DW'(DIGITS - 1);
   localparam logic [PW-1:0] POS_MAX  = PW'(RING_LEN - 1);
   localparam logic [AW-1:0] ACNT_MAX = AW'(ANIM_DIV - 1);

   // Active-low {a,b,c,d,e,f,g} pattern for one hex digit.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h01;
         4'h1: g = 7'h4F;
         4'h2: g = 7'h12;
         4'h3: g = 7'h06;
         4'h4: g = 7'h4C;
         4'h5: g = 7'h24;
         4'h6: g = 7'h20;
         4'h7: g = 7'h0D;
         4'h8: g = 7'h00;
         4'h9: g = 7'h04;
         4'hA: g = 7'h08;
         4'hB: g = 7'h60;
         4'hC: g = 7'h72;
         4'hD: g = 7'h42;
         4'hE: g = 7'h30;
         default: g = 7'h38;
      endcase
      return g;
   endfunction

   logic [SW-1:0]         scnt;
   logic [DW-1:0]         dig;
   logic [AW-1:0]         acnt;
   logic [PW-1:0]         pos;

   logic [4*DIGITS-1:0]   value_snap;
   logic [DIGITS-1:0]     dp_snap;
   logic                  lz_snap;
   logic [2:0]            bright_snap;

   logic                  frame_start;
   logic [SW:0]           bright_ext;
   logic [SW:0]           on_cnt;
   logic                  lit;
   logic [3:0]            nib;
   logic                  dp_on;
   logic                  lead_zero;
   logic                  blank;
   logic [7:0]            value_n;
   logic [7:0]            anim_n;
   int                    pos_i;
   int                    left_i;
   logic [7:0]            nfnd_p0;
   logic [DIGITS-1:0]     nanode_p0;

   assign frame_start = (scnt == '0) && (dig == DIG_MAX);

   // ---- stage p0: decode counters and snapshot into next panel drive ----

   // On-time in cycles is (BRIGHT+1)/8 of a slot. Slot cycle 0 stays dark
   // so that anode switching never shows the previous digit's segments.
   always_comb begin
      bright_ext = (SW+1)'(bright_snap) + (SW+1)'(1);
      on_cnt     = bright_ext << (SW - 3);
      lit        = (scnt != '0) && ({1'b0, scnt} < on_cnt);
   end

   // Value mode. Walking from the leftmost nibble down keeps a running
   // "everything so far is zero" flag, which is exactly the blanking rule.
   always_comb begin
      nib       = 4'h0;
      dp_on     = 1'b0;
      blank     = 1'b0;
      lead_zero = 1'b1;
      for (int p = DIGITS - 1; p >= 0; p--) begin
         lead_zero = lead_zero && (value_snap[4*p +: 4] == 4'h0);
         if (DW'(p) == dig) begin
            nib   = value_snap[4*p +: 4];
            dp_on = dp_snap[p];
            blank = lz_snap && lead_zero && (p != 0);
         end
      end
      value_n = {(blank ? 7'h7F : hex_glyph(nib)), ~dp_on};
   end

   // Waiting mode. The ring runs clockwise: top segments left to right,
   // down the right side, bottom segments right to left, up the left side.
   // left_i is the digit index counted from the left.
   always_comb begin
      pos_i  = int'(pos);
      left_i = DIGITS - 1 - int'(dig);
      anim_n = 8'hFF;
      if (pos_i < DIGITS) begin
         if (pos_i == left_i) anim_n[7] = 1'b0;
      end else if (pos_i == DIGITS) begin
         if (left_i == DIGITS - 1) anim_n[6] = 1'b0;
      end else if (pos_i == DIGITS + 1) begin
         if (left_i == DIGITS - 1) anim_n[5] = 1'b0;
      end else if (pos_i <= 2 * DIGITS + 1) begin
         if (2 * DIGITS + 1 - pos_i == left_i) anim_n[4] = 1'b0;
      end else if (pos_i == RING_LEN - 2) begin
         if (left_i == 0) anim_n[3] = 1'b0;
      end else begin
         if (left_i == 0) anim_n[2] = 1'b0;
      end
   end

   always_comb begin
      nfnd_p0   = nWAIT ? value_n : anim_n;
      nanode_p0 = '1;
      if (lit) nanode_p0[dig] = 1'b0;
   end

   // ---- stage p1: registered panel outputs ----
   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         nFND   <= 8'hFF;
         nANODE <= '1;
      end else begin
         nFND   <= nfnd_p0;
         nANODE <= nanode_p0;
      end
   end

   // Scan position: slot cycle counter and current digit.
   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         scnt <= '0;
         dig  <= DIG_MAX;
      end else begin
         if (scnt == SCNT_MAX) begin
            scnt <= '0;
            dig  <= (dig == '0) ? DIG_MAX : dig - DW'(1);
         end else begin
            scnt <= scnt + SW'(1);
         end
      end
   end

   // Frame-coherent capture of the display inputs.
   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         value_snap  <= '0;
         dp_snap     <= '0;
         lz_snap     <= 1'b0;
         bright_snap <= 3'd0;
      end else if (frame_start) begin
         value_snap  <= VALUE;
         dp_snap     <= DP_MASK;
         lz_snap     <= LZ_BLANK;
         bright_snap <= BRIGHT;
      end
   end

   // Animation step counter; held at zero outside a wait episode so every
   // episode starts from the top-left segment.
   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         acnt <= '0;
         pos  <= '0;
      end else if (nWAIT) begin
         acnt <= '0;
         pos  <= '0;
      end else if (acnt == ACNT_MAX) begin
         acnt <= '0;
         pos  <= (pos == POS_MAX) ? '0 : pos + PW'(1);
      end else begin
         acnt <= acnt + AW'(1);
      end
   end

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 16;
   localparam int ANIM_DIV = 8;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic        MCLK = 1'b0;
   logic        nRESET = 1'b1;
   logic        nWAIT = 1'b1;
   logic [11:0] VALUE = 12'h000;
   logic [2:0]  DP_MASK = 3'b000;
   logic        LZ_BLANK = 1'b0;
   logic [2:0]  BRIGHT = 3'd0;
   logic [7:0]  nFND;
   logic [2:0]  nANODE;

   fnd_scan_driver #(
      .DIGITS  (DIGITS),
      .SCAN_DIV(SCAN_DIV),
      .ANIM_DIV(ANIM_DIV)
   ) dut (
      .MCLK    (MCLK),
      .nRESET  (nRESET),
      .nWAIT   (nWAIT),
      .VALUE   (VALUE),
      .DP_MASK (DP_MASK),
      .LZ_BLANK(LZ_BLANK),
      .BRIGHT  (BRIGHT),
      .nFND    (nFND),
      .nANODE  (nANODE)
   );

   always #5 MCLK = ~MCLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] fnd;
      logic [2:0] an;
      logic       chk_fnd;
   } exp_t;

   exp_t q[$];

   // Glyph table written exactly as the panel documentation lists it.
   logic [7:0] glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1B,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};
   // Chase ring: digit position and segment (0=a .. 5=f) for each step.
   int ring_dig [10] = '{2, 1, 0, 0, 0, 0, 1, 2, 2, 2};
   int ring_seg [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 5};

   int          m_cnt  = 0;   // edges since reset release
   int          m_wait = 0;   // consecutive waiting edges
   logic [11:0] s_val  = '0;
   logic [2:0]  s_dp   = '0;
   logic        s_lz   = 1'b0;
   logic [2:0]  s_br   = '0;

   always @(negedge nRESET) begin
      m_cnt = 0; m_wait = 0;
      s_val = '0; s_dp = '0; s_lz = 1'b0; s_br = '0;
   end

   always @(posedge MCLK) begin
      exp_t e;
      int s, d, on, p;
      logic [11:0] upper;
      if (!nRESET) begin
         e.fnd = 8'hFF; e.an = 3'b111; e.chk_fnd = 1'b1;
         q.push_back(e);
      end else begin
         s  = m_cnt % SCAN_DIV;
         d  = DIGITS - 1 - (m_cnt / SCAN_DIV) % DIGITS;
         on = (int'(s_br) + 1) * SCAN_DIV / 8;
         e.an = 3'b111;
         e.chk_fnd = (s >= 1) && (s < on);
         if (e.chk_fnd) e.an[d] = 1'b0;
         if (nWAIT) begin
            upper = s_val >> (4 * d);
            if (s_lz && d > 0 && upper == 12'h000) e.fnd[7:1] = 7'h7F;
            else e.fnd = glyph_tab[int'(upper & 12'h00F)];
            e.fnd[0] = ~s_dp[d];
         end else begin
            p = (m_wait / ANIM_DIV) % 10;
            e.fnd = 8'hFF;
            if (ring_dig[p] == d) e.fnd[7 - ring_seg[p]] = 1'b0;
         end
         q.push_back(e);
         if (m_cnt % FRAME == 0) begin
            s_val = VALUE; s_dp = DP_MASK; s_lz = LZ_BLANK; s_br = BRIGHT;
         end
         m_cnt++;
         m_wait = nWAIT ? 0 : m_wait + 1;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge MCLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("anode", {5'b0, nANODE}, {5'b0, e.an});
         if (e.chk_fnd) check("segments", nFND, e.fnd);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge MCLK);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < 3; i++)
         VALUE[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      DP_MASK  = 3'($urandom_range(0, 7));
      LZ_BLANK = 1'($urandom_range(0, 1));
      BRIGHT   = 3'($urandom_range(0, 7));
   endtask

   initial begin
      int guard;
      #1 nRESET = 1'b0;
      VALUE = 12'h3A0; BRIGHT = 3'd7; nWAIT = 1'b1;
      cycles(3);
      nRESET = 1'b1;

      // basic scan at full brightness
      cycles(2 * FRAME);

      // leading-zero blanking with a decimal point on a blanked digit
      VALUE = 12'h005; LZ_BLANK = 1'b1; DP_MASK = 3'b010;
      cycles(2 * FRAME);

      // mid-frame change must wait for the next frame
      cycles(20);
      VALUE = 12'hB7E; LZ_BLANK = 1'b0; DP_MASK = 3'b101;
      cycles(2 * FRAME);

      // lowest and middle brightness
      BRIGHT = 3'd0;
      cycles(2 * FRAME);
      BRIGHT = 3'd3;
      cycles(2 * FRAME);

      // waiting animation, full wrap, then restart
      BRIGHT = 3'd7;
      nWAIT = 1'b0;
      cycles(90);
      nWAIT = 1'b1;
      cycles(5);
      nWAIT = 1'b0;
      cycles(30);
      nWAIT = 1'b1;
      cycles(FRAME);

      // asynchronous reset in the middle of digit 1
      guard = 0;
      while ((m_cnt % FRAME) != SCAN_DIV + 9 && guard < 4 * FRAME) begin
         cycles(1);
         guard++;
      end
      if (guard >= 4 * FRAME) check("reset_sync_timeout", 8'd1, 8'd0);
      VALUE = 12'h0C4;
      #1 nRESET = 1'b0;
      #1;
      check("async_reset_fnd", nFND, 8'hFF);
      check("async_reset_anode", {5'b0, nANODE}, 8'h07);
      #1 nRESET = 1'b1;
      cycles(2 * FRAME);

      // randomized traffic
      for (int c = 0; c < 20 * FRAME; c++) begin
         if ($urandom_range(0, 7) == 0) rand_inputs();
         if ($urandom_range(0, 39) == 0) nWAIT = ~nWAIT;
         cycles(1);
      end
      nWAIT = 1'b1;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
